// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding select codes, divider states and match helper
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  // A producer matches a consumer only when it writes a nonzero register
  function automatic logic reg_match(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// rtl/div_stall_fsm.sv - multi-cycle divider occupancy tracker that holds the pipeline
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic div_startE,
  output logic div_hold,
  output logic div_busy
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  div_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // State and occupancy counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state; the final count releases the pipeline in the same cycle it leaves BUSY
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_hold = 1'b0;
    div_busy = (state != IDLE);
    case (state)
      IDLE: begin
        if (div_startE) begin
          state_n = BUSY;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n    = cnt + 1'b1;
          div_hold = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding/stall/flush controller; divider hold enabled by HAZARD_DIV_STALL_EN
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       div_startE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       div_busy
);

  logic       div_hold;
  logic       lwstall;
  logic       branchstall;
  logic [1:0] fwd_a_n;
  logic [1:0] fwd_b_n;

  // Selects are precomputed in D, so E-stage sources and the W producer are not needed
  logic unused_inputs;
  assign unused_inputs = ^{rsE, rtE, writeregW, regwriteW};

`ifdef HAZARD_DIV_STALL_EN
  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_stall_fsm (
    .clk       (clk),
    .resetn    (resetn),
    .div_startE(div_startE),
    .div_hold  (div_hold),
    .div_busy  (div_busy)
  );
`else
  logic unused_div;
  assign unused_div = div_startE ^ (DIV_CYCLES != 0);
  assign div_hold   = 1'b0;
  assign div_busy   = 1'b0;
`endif

  // Next-cycle execute selects: the producer now in E is younger than the one in M
  always_comb begin
    fwd_a_n = FWD_RF;
    fwd_b_n = FWD_RF;
    if (reg_match(regwriteE, writeregE, rsD))      fwd_a_n = FWD_MEM;
    else if (reg_match(regwriteM, writeregM, rsD)) fwd_a_n = FWD_WB;
    if (reg_match(regwriteE, writeregE, rtD))      fwd_b_n = FWD_MEM;
    else if (reg_match(regwriteM, writeregM, rtD)) fwd_b_n = FWD_WB;
  end

  // Load-use and decode-resolved branch hazards
  always_comb begin
    lwstall     = memtoregE && (writeregE != 5'd0) &&
                  ((writeregE == rsD) || (writeregE == rtD));
    branchstall = (branchD || jrD) &&
                  ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                   (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  end

  assign forwardAD = reg_match(regwriteM, writeregM, rsD) && !memtoregM;
  assign forwardBD = reg_match(regwriteM, writeregM, rtD) && !memtoregM;
  assign stallF    = lwstall | branchstall | div_hold;
  assign stallD    = stallF;
  assign flushE    = (lwstall | branchstall) & ~div_hold;

  // D->E select register: a flushed bubble reads the register file, a stall holds
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      forwardAE <= FWD_RF;
      forwardBE <= FWD_RF;
    end else if (flushE) begin
      forwardAE <= FWD_RF;
      forwardBE <= FWD_RF;
    end else if (!stallD) begin
      forwardAE <= fwd_a_n;
      forwardBE <= fwd_b_n;
    end
  end

endmodule
